// File: rtl/uart_tx_sched.sv
// Purpose: round-robin, packet-granular scheduler sharing one 8N1 txd line among NUM_REQ requesters.
// Latency: grant/ack one cycle after req is seen in IDLE; start bit on the first baud tick after that.
// Backpressure: a requester holds req/data until its ack; the line is held for the whole packet.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 baud_en,
  input  logic                 bps_tick,
  output logic                 txd,
  output logic                 busy,
  output logic [OWN_W-1:0]     owner
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic             last_q;
  logic [3:0]       bitcnt;
  logic [OWN_W-1:0] ptr;

  logic             win_vld;
  logic [OWN_W-1:0] win_idx;
  logic [7:0]       win_byte;
  logic             win_last;
  logic [7:0]       own_byte;
  logic             own_last;
  logic [OWN_W-1:0] ptr_nxt;

  // Round-robin search from ptr, wrapping modulo NUM_REQ; lowest offset wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'(idx);
      end
    end
  end

  // Byte/last selection for the search winner, the current owner, and the post-release pointer.
  always_comb begin
    win_byte = req_data[8*int'(win_idx) +: 8];
    win_last = req_last[win_idx];
    own_byte = req_data[8*int'(owner) +: 8];
    own_last = req_last[owner];
    ptr_nxt  = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
  end

  // Frame sequencer: grant, start/data/stop bits on baud ticks, packet continue or release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      last_q  <= 1'b0;
      bitcnt  <= '0;
      ptr     <= '0;
      owner   <= '0;
      gnt     <= '0;
      ack     <= '0;
      baud_en <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (win_vld) begin
            shreg          <= win_byte;
            last_q         <= win_last;
            owner          <= win_idx;
            gnt            <= '0;
            gnt[win_idx]   <= 1'b1;
            ack[win_idx]   <= 1'b1;
            baud_en        <= 1'b1;
            busy           <= 1'b1;
            state          <= SYNC;
          end
        end
        SYNC: begin
          if (bps_tick) begin
            txd    <= 1'b0;
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (bps_tick) begin
            if (bitcnt == 4'd8) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd    <= shreg[bitcnt[2:0]];
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (bps_tick) begin
            if (!last_q && req[owner]) begin
              // Next frame's start bit abuts this stop bit: no idle bit inside a packet.
              shreg      <= own_byte;
              last_q     <= own_last;
              ack[owner] <= 1'b1;
              txd        <= 1'b0;
              bitcnt     <= '0;
              state      <= DATA;
            end else begin
              gnt     <= '0;
              baud_en <= 1'b0;
              busy    <= 1'b0;
              ptr     <= ptr_nxt;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  localparam int N   = 4;
  localparam int BIT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         baud_en;
  logic         bps_tick;
  logic         txd;
  logic         busy;
  logic [1:0]   owner;

  int checks = 0;
  int errors = 0;

  logic [8:0] rq [N][$];      // per-requester pending {last, byte}
  int         exp_ack[$];     // expected ack owner sequence
  logic [8:0] exp_frm[$];     // expected frames {contiguous, byte}
  int         rx_st = 0;

  uart_tx_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .ack(ack), .baud_en(baud_en), .bps_tick(bps_tick),
    .txd(txd), .busy(busy), .owner(owner)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Baud generator model: one-cycle tick every BIT cycles while enabled.
  initial begin
    int bcnt;
    bcnt = 0;
    bps_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || baud_en !== 1'b1) begin
        bcnt = 0;
        bps_tick = 1'b0;
      end else begin
        bcnt++;
        bps_tick = (bcnt == BIT);
        if (bcnt == BIT) bcnt = 0;
      end
    end
  end

  // Requester models: present queue head, advance on ack.
  initial begin
    req = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        req[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end
      end
    end
  end

  // Monitor: acks vs scoreboard, grant/baud protocol, tick-aligned txd, serial receiver.
  initial begin
    logic [N-1:0] pg;
    logic pb, ptxd;
    int cyc, rx_cnt, rx_start, last_start, gap, e;
    logic [7:0] rx_byte;
    logic [8:0] ef;
    pg = '0; pb = 1'b0; ptxd = 1'b1; cyc = 0; rx_cnt = 0; rx_start = 0;
    last_start = -1000; gap = 0; rx_byte = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst !== 1'b0) begin
        rx_st = 0;
      end else begin
        if (ack != '0) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
          else begin
            e = exp_ack.pop_front();
            chk("ack_onehot", 32'(ack), 32'd1 << e);
            chk("gnt_at_ack", 32'(gnt), 32'd1 << e);
            chk("owner_at_ack", 32'(owner), 32'(e));
            chk("baud_en_at_ack", 32'(baud_en), 32'd1);
          end
        end
        if (gnt != '0) chk("baud_en_hold", 32'(baud_en), 32'd1);
        if (gnt != pg) begin
          if (pg != '0 && gnt != '0) chk("gnt_switch", 32'(gnt), 32'(pg));
          if (pg == '0 && gnt != '0) chk("baud_gap_before_grant", 32'(pb), 32'd0);
          if (gnt == '0) begin
            chk("release_baud_en", 32'(baud_en), 32'd0);
            chk("release_busy", 32'(busy), 32'd0);
            chk("release_on_tick", 32'(bps_tick), 32'd1);
          end
        end
        if (txd != ptxd) chk("txd_on_tick", 32'(bps_tick), 32'd1);
        if (rx_st == 0) begin
          if (ptxd == 1'b1 && txd == 1'b0) begin
            rx_st = 1; rx_cnt = 0; rx_start = cyc; gap = cyc - last_start;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt == 8) chk("start_bit", 32'(txd), 32'd0);
          else if (rx_cnt > 8 && rx_cnt < 152 && (rx_cnt - 8) % BIT == 0)
            rx_byte[(rx_cnt - 8) / BIT - 1] = txd;
          else if (rx_cnt == 152) begin
            chk("stop_bit", 32'(txd), 32'd1);
            if (exp_frm.size() == 0) chk("frame_unexpected", 32'(rx_byte), 32'hFFFF);
            else begin
              ef = exp_frm.pop_front();
              chk("frame_byte", 32'(rx_byte), 32'(ef[7:0]));
              if (ef[8]) chk("frame_contig_gap", 32'(gap), 32'd160);
            end
            last_start = rx_start;
            rx_st = 0;
          end
        end
      end
      pg = gnt; pb = baud_en; ptxd = txd;
    end
  end

  task automatic push_req(input int idx, input logic [7:0] b, input logic last);
    rq[idx].push_back({last, b});
  endtask

  task automatic expect_frame(input int idx, input logic [7:0] b, input logic contig);
    exp_ack.push_back(idx);
    exp_frm.push_back({contig, b});
  endtask

  task automatic wait_idle();
    int n;
    bit pend;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pend = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) pend = 1'b1;
    end while ((pend || busy || rx_st != 0) && n < 5000);
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL wait_idle_timeout actual=%0d cycles required<5000", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_baud_en", 32'(baud_en), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: all four requesting, single-byte packets, ptr=0
    push_req(0, 8'h11, 1'b1); push_req(1, 8'h22, 1'b1); push_req(2, 8'h33, 1'b1);
    push_req(3, 8'h44, 1'b1); push_req(0, 8'h55, 1'b1);
    expect_frame(0, 8'h11, 1'b0); expect_frame(1, 8'h22, 1'b0); expect_frame(2, 8'h33, 1'b0);
    expect_frame(3, 8'h44, 1'b0); expect_frame(0, 8'h55, 1'b0);
    wait_idle();

    // Single byte 0xA5 from requester 1 (ptr=1)
    push_req(1, 8'hA5, 1'b1);
    expect_frame(1, 8'hA5, 1'b0);
    wait_idle();
    chk("single_owner", 32'(owner), 32'd1);
    chk("single_gnt_idle", 32'(gnt), 32'd0);

    // Packet of three bytes from requester 0 (ptr=2 wraps to 0)
    push_req(0, 8'h01, 1'b0); push_req(0, 8'h02, 1'b0); push_req(0, 8'h03, 1'b1);
    expect_frame(0, 8'h01, 1'b0); expect_frame(0, 8'h02, 1'b1); expect_frame(0, 8'h03, 1'b1);
    wait_idle();

    // Pointer priority: owner 2 completes, then req=1001 -> 3 then 0
    push_req(2, 8'h77, 1'b1);
    expect_frame(2, 8'h77, 1'b0);
    wait_idle();
    push_req(3, 8'h88, 1'b1); push_req(0, 8'h99, 1'b1);
    expect_frame(3, 8'h88, 1'b0); expect_frame(0, 8'h99, 1'b0);
    wait_idle();

    // Early drop: requester 2 sends 0x5A last=0 then drops; ptr becomes 3
    push_req(2, 8'h5A, 1'b0);
    expect_frame(2, 8'h5A, 1'b0);
    wait_idle();
    chk("drop_owner", 32'(owner), 32'd2);
    push_req(1, 8'h66, 1'b1); push_req(3, 8'hCC, 1'b1);
    expect_frame(3, 8'hCC, 1'b0); expect_frame(1, 8'h66, 1'b0);
    wait_idle();

    // Reset during data bit 4 of a frame from requester 2
    push_req(2, 8'hC3, 1'b1);
    exp_ack.push_back(2);
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_grant_seen", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_baud_en", 32'(baud_en), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_req(1, 8'hE7, 1'b1); push_req(2, 8'h3C, 1'b1);
    expect_frame(1, 8'hE7, 1'b0); expect_frame(2, 8'h3C, 1'b0);
    wait_idle();

    chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    chk("frame_queue_drained", 32'(exp_frm.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
